// File: rtl/load_store_unit.sv
// RV32I load/store unit: alignment check, req/gnt/rvalid memory
// handshake, load extension and a timeout that abandons stuck accesses.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        misaligned,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       f3_q;
    logic [1:0]       off_q;
    logic             mis_q;
    logic             err_q;
    logic             illegal;
    logic             fault;
    logic             tmo;
    logic [3:0]       be_c;
    logic [31:0]      wd_c;
    logic [31:0]      ld_c;
    logic [7:0]       ld_b;
    logic [15:0]      ld_h;

    assign done       = (state == RESP);
    assign misaligned = done & mis_q;
    assign err        = done & err_q;
    assign stall      = req_valid & ~done;
    assign tmo        = (cnt == CNT_W'(TIMEOUT_CYCLES));

    // Decode the incoming request: fault detection, lanes and store data
    always_comb begin
        illegal = 1'b0;
        be_c    = 4'b1111;
        wd_c    = req_wdata;
        if (req_we) begin
            illegal = (req_funct3 >= 3'd3);
        end else begin
            illegal = (req_funct3 == 3'd3) || (req_funct3[2:1] == 2'b11);
        end
        fault = illegal
              | ((req_funct3[1:0] == 2'd1) & req_addr[0])
              | ((req_funct3[1:0] == 2'd2) & (req_addr[1:0] != 2'b00));
        case (req_funct3[1:0])
            2'd0: begin
                be_c = 4'b0001 << req_addr[1:0];
                wd_c = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                be_c = 4'b0011 << {req_addr[1], 1'b0};
                wd_c = {2{req_wdata[15:0]}};
            end
            default: begin
                be_c = 4'b1111;
                wd_c = req_wdata;
            end
        endcase
    end

    // Pick the addressed lane out of the returned word and extend it
    always_comb begin
        ld_b = mem_rdata[{off_q, 3'b000} +: 8];
        ld_h = mem_rdata[{off_q[1], 4'b0000} +: 16];
        case (f3_q)
            3'd0:    ld_c = {{24{ld_b[7]}}, ld_b};
            3'd4:    ld_c = {24'b0, ld_b};
            3'd1:    ld_c = {{16{ld_h[15]}}, ld_h};
            3'd5:    ld_c = {16'b0, ld_h};
            default: ld_c = mem_rdata;
        endcase
    end

    // Next-state logic; a completed handshake wins over a same-cycle timeout
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    state_nx = fault ? RESP : REQ;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    state_nx = mem_we ? RESP : WAIT;
                end else if (tmo) begin
                    state_nx = RESP;
                end
            end
            WAIT: begin
                if (mem_rvalid || tmo) begin
                    state_nx = RESP;
                end
            end
            RESP: state_nx = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Latched access, memory port registers, timeout counter and result
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt       <= '0;
            f3_q      <= 3'b0;
            off_q     <= 2'b0;
            mis_q     <= 1'b0;
            err_q     <= 1'b0;
            rdata     <= 32'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'b0;
            mem_be    <= 4'b0;
            mem_wdata <= 32'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (req_valid) begin
                        f3_q  <= req_funct3;
                        off_q <= req_addr[1:0];
                        mis_q <= fault;
                        err_q <= 1'b0;
                        if (!fault) begin
                            mem_req   <= 1'b1;
                            mem_we    <= req_we;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_be    <= be_c;
                            mem_wdata <= wd_c;
                        end
                    end
                end
                REQ: begin
                    cnt <= cnt + CNT_W'(1);
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                    end else if (tmo) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        err_q   <= 1'b1;
                        rdata   <= 32'b0;
                    end
                end
                WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                    if (mem_rvalid) begin
                        rdata <= ld_c;
                    end else if (tmo) begin
                        err_q <= 1'b1;
                        rdata <= 32'b0;
                    end
                end
                RESP: begin
                    cnt   <= '0;
                    mis_q <= 1'b0;
                    err_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: scoreboarded accesses
// driven through a cycle-accurate memory responder.
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        done;
    logic [31:0] rdata;
    logic        misaligned;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       nm;
        int          cyc;
        logic        mis;
        logic        err;
        logic        acc;
        logic [31:0] rdata;
        logic [31:0] maddr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } exp_t;

    exp_t sb[$];

    load_store_unit #(
        .TIMEOUT_CYCLES(8),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_we(req_we),
        .req_funct3(req_funct3),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .stall(stall),
        .done(done),
        .rdata(rdata),
        .misaligned(misaligned),
        .err(err),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_be(mem_be),
        .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic run_op(
        input string       nm,
        input logic        we,
        input logic [2:0]  f3,
        input logic [31:0] addr,
        input logic [31:0] wdata,
        input logic [31:0] word,
        input logic        give_gnt,
        input int          ecyc,
        input logic        emis,
        input logic        eerr,
        input logic        eacc,
        input logic [31:0] erdata,
        input logic [31:0] emaddr,
        input logic [3:0]  ebe,
        input logic [31:0] ewdata
    );
        exp_t e;
        exp_t got;
        int   cyc;
        int   gnt_cyc;
        logic seen;
        logic fin;
        e.nm = nm; e.cyc = ecyc; e.mis = emis; e.err = eerr; e.acc = eacc;
        e.rdata = erdata; e.maddr = emaddr; e.be = ebe; e.wdata = ewdata;
        sb.push_back(e);
        req_valid = 1'b1; req_we = we; req_funct3 = f3;
        req_addr = addr; req_wdata = wdata;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = word;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL %s stall_c0 got %b want 1", nm, stall);
        end
        cyc = 0; gnt_cyc = -1; seen = 1'b0; fin = 1'b0;
        while (!fin && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            mem_gnt = 1'b0;
            mem_rvalid = 1'b0;
            if (done) begin
                fin = 1'b1;
                got = sb.pop_front();
                checks++;
                if (cyc != got.cyc) begin
                    errors++;
                    $display("FAIL %s done_cycle got %0d want %0d", got.nm, cyc, got.cyc);
                end
                checks++;
                if (misaligned !== got.mis) begin
                    errors++;
                    $display("FAIL %s misaligned got %b want %b", got.nm, misaligned, got.mis);
                end
                checks++;
                if (err !== got.err) begin
                    errors++;
                    $display("FAIL %s err got %b want %b", got.nm, err, got.err);
                end
                checks++;
                if (rdata !== got.rdata) begin
                    errors++;
                    $display("FAIL %s rdata got %h want %h", got.nm, rdata, got.rdata);
                end
                checks++;
                if (stall !== 1'b0 || mem_req !== 1'b0) begin
                    errors++;
                    $display("FAIL %s resp_stall_req got %b%b want 00", got.nm, stall, mem_req);
                end
                checks++;
                if (seen !== got.acc) begin
                    errors++;
                    $display("FAIL %s mem_access got %b want %b", got.nm, seen, got.acc);
                end
            end else begin
                if (mem_req && !seen) begin
                    seen = 1'b1;
                    checks++;
                    if (mem_addr !== e.maddr || mem_be !== e.be || mem_wdata !== e.wdata || mem_we !== we) begin
                        errors++;
                        $display("FAIL %s mem_port got a=%h be=%b wd=%h we=%b want a=%h be=%b wd=%h we=%b",
                                 nm, mem_addr, mem_be, mem_wdata, mem_we, e.maddr, e.be, e.wdata, we);
                    end
                end
                if (mem_req && give_gnt && gnt_cyc < 0) begin
                    mem_gnt = 1'b1;
                    gnt_cyc = cyc;
                end else if (gnt_cyc >= 0 && cyc == gnt_cyc + 1 && !we) begin
                    mem_rvalid = 1'b1;
                end
            end
        end
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL %s done_timeout got none want cycle %0d", nm, ecyc);
            void'(sb.pop_front());
        end
        req_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (mem_req !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s after_idle got req=%b done=%b want 00", nm, mem_req, done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({done, misaligned, err, mem_req, mem_we, stall} !== 6'b0 ||
            mem_addr !== 32'b0 || mem_be !== 4'b0 || mem_wdata !== 32'b0 || rdata !== 32'b0) begin
            errors++;
            $display("FAIL reset got d=%b m=%b e=%b r=%b we=%b a=%h be=%b wd=%h rd=%h want all 0",
                     done, misaligned, err, mem_req, mem_we, mem_addr, mem_be, mem_wdata, rdata);
        end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_store();
        run_op("sw", 1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0, 1'b1,
               2, 1'b0, 1'b0, 1'b1, 32'h0, 32'h100, 4'b1111, 32'hDEADBEEF);
        run_op("sh", 1'b1, 3'd1, 32'h202, 32'h1234ABCD, 32'h0, 1'b1,
               2, 1'b0, 1'b0, 1'b1, 32'h0, 32'h200, 4'b1100, 32'hABCDABCD);
        run_op("sb", 1'b1, 3'd0, 32'h001, 32'h000000A5, 32'h0, 1'b1,
               2, 1'b0, 1'b0, 1'b1, 32'h0, 32'h000, 4'b0010, 32'hA5A5A5A5);
    endtask

    task automatic test_load();
        run_op("lb", 1'b0, 3'd0, 32'h103, 32'h0, 32'h80AA55CC, 1'b1,
               3, 1'b0, 1'b0, 1'b1, 32'hFFFFFF80, 32'h100, 4'b1000, 32'h0);
        run_op("lbu", 1'b0, 3'd4, 32'h103, 32'h0, 32'h80AA55CC, 1'b1,
               3, 1'b0, 1'b0, 1'b1, 32'h00000080, 32'h100, 4'b1000, 32'h0);
        run_op("lh", 1'b0, 3'd1, 32'h102, 32'h0, 32'h80AA55CC, 1'b1,
               3, 1'b0, 1'b0, 1'b1, 32'hFFFF80AA, 32'h100, 4'b1100, 32'h0);
        run_op("lhu", 1'b0, 3'd5, 32'h100, 32'h0, 32'h80AA55CC, 1'b1,
               3, 1'b0, 1'b0, 1'b1, 32'h000055CC, 32'h100, 4'b0011, 32'h0);
        run_op("lw", 1'b0, 3'd2, 32'h104, 32'h0, 32'h13579BDF, 1'b1,
               3, 1'b0, 1'b0, 1'b1, 32'h13579BDF, 32'h104, 4'b1111, 32'h0);
    endtask

    task automatic test_fault();
        run_op("lw_mis", 1'b0, 3'd2, 32'h101, 32'h0, 32'h0, 1'b1,
               1, 1'b1, 1'b0, 1'b0, 32'h13579BDF, 32'h0, 4'b0, 32'h0);
        run_op("ld_f3_3", 1'b0, 3'd3, 32'h100, 32'h0, 32'h0, 1'b1,
               1, 1'b1, 1'b0, 1'b0, 32'h13579BDF, 32'h0, 4'b0, 32'h0);
        run_op("lh_odd", 1'b0, 3'd5, 32'h103, 32'h0, 32'h0, 1'b1,
               1, 1'b1, 1'b0, 1'b0, 32'h13579BDF, 32'h0, 4'b0, 32'h0);
        run_op("st_f3_4", 1'b1, 3'd4, 32'h100, 32'h0, 32'h0, 1'b1,
               1, 1'b1, 1'b0, 1'b0, 32'h13579BDF, 32'h0, 4'b0, 32'h0);
    endtask

    task automatic test_timeout();
        run_op("lh_tmo", 1'b0, 3'd1, 32'h400, 32'h0, 32'h0, 1'b0,
               10, 1'b0, 1'b1, 1'b1, 32'h0, 32'h400, 4'b0011, 32'h0);
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2;
        req_addr = 32'h300; req_wdata = 32'h0;
        @(posedge clk); #1;
        mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        req_valid = 1'b0;
        checks++;
        if ({done, misaligned, err, mem_req, mem_we} !== 5'b0 ||
            mem_addr !== 32'b0 || mem_be !== 4'b0 || mem_wdata !== 32'b0 || rdata !== 32'b0) begin
            errors++;
            $display("FAIL reset_mid got d=%b m=%b e=%b r=%b we=%b a=%h be=%b wd=%h rd=%h want all 0",
                     done, misaligned, err, mem_req, mem_we, mem_addr, mem_be, mem_wdata, rdata);
        end
        run_op("lw_after_rst", 1'b0, 3'd2, 32'h304, 32'h0, 32'hCAFEF00D, 1'b1,
               3, 1'b0, 1'b0, 1'b1, 32'hCAFEF00D, 32'h304, 4'b1111, 32'h0);
    endtask

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'h0; req_wdata = 32'h0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        test_reset();
        test_store();
        test_load();
        test_fault();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
